wb_bus_arbiter: RTL

//  Two-master, one-slave Wishbone classic arbiter. Shares the single SoC data bus

---
 rtl/wb_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master, one-slave Wishbone classic arbiter.
// M0 is the instruction-fetch master and M1 is the load/store master. Grant is
// round-robin on ties and is held for the whole bus cycle (while CYC stays high).
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort cycles that a slave never
// acknowledges within TIMEOUT_CYCLES strobe cycles.
module wb_bus_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  // M0: instruction fetch
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  output logic            m0_err,
  // M1: load/store
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            m1_err,
  // Slave side
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [DW/8-1:0] s_sel,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last_gnt;   // 0: M0 won the last tie, 1: M1 won it
  logic   gnt0, gnt1;
  logic   gnt_cyc;    // CYC of whichever master currently owns the bus
  logic   gnt_stb;    // STB qualified by CYC of the owning master
  logic   timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign gnt_cyc = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);
  assign gnt_stb = (gnt0 & m0_cyc & m0_stb) | (gnt1 & m1_cyc & m1_stb);

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] timer;

  // Abort when the slave has left the strobe unanswered for the full window.
  assign timeout = gnt_stb & ~s_ack & (timer == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: count unanswered strobe cycles of the current owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (!gnt_cyc || s_ack || timeout) begin
      timer <= '0;
    end else if (gnt_stb) begin
      timer <= timer + 16'd1;
    end
  end

  assign m0_err = gnt0 & timeout & ~rst;
  assign m1_err = gnt1 & timeout & ~rst;
`else
  assign timeout = 1'b0;
  assign m0_err  = 1'b0;
  assign m1_err  = 1'b0;
`endif

  // Grant FSM: arbitrate only from IDLE, hold the grant until the owner drops CYC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            if (last_gnt) begin
              state    <= GNT0;
              last_gnt <= 1'b0;
            end else begin
              state    <= GNT1;
              last_gnt <= 1'b1;
            end
          end else if (m0_cyc) begin
            state <= GNT0;
          end else if (m1_cyc) begin
            state <= GNT1;
          end
        end
        GNT0:    if (!m0_cyc || timeout) state <= IDLE;
        GNT1:    if (!m1_cyc || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Slave request mux: everything is zero unless a master owns the bus.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    if (gnt0) begin
      s_cyc   = m0_cyc & ~timeout;
      s_stb   = m0_cyc & m0_stb & ~timeout;
      s_we    = m0_we;
      s_sel   = m0_sel;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
    end else if (gnt1) begin
      s_cyc   = m1_cyc & ~timeout;
      s_stb   = m1_cyc & m1_stb & ~timeout;
      s_we    = m1_we;
      s_sel   = m1_sel;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
    end
  end

  // Read data is broadcast; an ack reaches only the owner, and never during reset.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = gnt0 & s_ack & ~rst;
  assign m1_ack   = gnt1 & s_ack & ~rst;

endmodule
